// File: rtl/snake_pkg.sv
// Shared definitions for the snake movement controller.
// Holds the grid and length defaults, the direction and FSM state
// encodings, the reset snake layout and a small direction helper.
package snake_pkg;

   localparam int GRID_W_DEF  = 64;
   localparam int GRID_H_DEF  = 48;
   localparam int MAX_LEN_DEF = 16;

   localparam logic [4:0] LEN_INIT = 5'd3;

   typedef enum logic [1:0] {
      DIR_DOWN  = 2'b00,
      DIR_RIGHT = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_UP    = 2'b11
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_CHECK = 2'b10,
      ST_DEAD  = 2'b11
   } state_t;

   // With this encoding the reverse direction is simply the bitwise inverse.
   function automatic dir_t opposite(input dir_t d);
      return dir_t'(~d);
   endfunction

   // Reset snake: head (32,24) with two segments trailing to the left.
   function automatic logic [5:0] init_x(input int idx);
      case (idx)
         0:       return 6'd32;
         1:       return 6'd31;
         2:       return 6'd30;
         default: return 6'd0;
      endcase
   endfunction

   function automatic logic [5:0] init_y(input int idx);
      return (idx < 3) ? 6'd24 : 6'd0;
   endfunction

endpackage

// File: rtl/snake_move_ctrl_if.sv
// Signal bundle between the game logic/VGA side and snake_move_ctrl.
// There is no valid/ready handshake here: iTick and iStart are one-cycle
// strobes sampled on the rising clock edge, the buttons are debounced
// levels, and every output is a registered level except oEat, which is a
// one-cycle pulse. master = the driver of the inputs, slave = the controller.
interface snake_move_ctrl_if;
   logic       iTick;
   logic       iUpButton;
   logic       iDownButton;
   logic       iLeftButton;
   logic       iRightButton;
   logic       iStart;
   logic [5:0] iFood_X;
   logic [5:0] iFood_Y;
   logic [5:0] iQuery_X;
   logic [5:0] iQuery_Y;
   logic       oSnake_Pix;
   logic [5:0] oHead_X;
   logic [5:0] oHead_Y;
   logic [4:0] oLen;
   logic       oEat;
   logic [1:0] oState;

   modport master (
      output iTick, iUpButton, iDownButton, iLeftButton, iRightButton, iStart,
             iFood_X, iFood_Y, iQuery_X, iQuery_Y,
      input  oSnake_Pix, oHead_X, oHead_Y, oLen, oEat, oState
   );

   modport slave (
      input  iTick, iUpButton, iDownButton, iLeftButton, iRightButton, iStart,
             iFood_X, iFood_Y, iQuery_X, iQuery_Y,
      output oSnake_Pix, oHead_X, oHead_Y, oLen, oEat, oState
   );
endinterface

// File: rtl/snake_dir_latch.sv
// Button edge detector, priority resolver and reversal filter.
// Ports: iCLK/iRST clock and async reset; iReinit restores the pending
// direction on restart; iUp/iDown/iLeft/iRight debounced button levels;
// iCommitted the direction the snake is currently moving; oPending the
// last accepted request, consumed by the controller on the next move.
module snake_dir_latch
   import snake_pkg::*;
(
   input  logic iCLK,
   input  logic iRST,
   input  logic iReinit,
   input  logic iUp,
   input  logic iDown,
   input  logic iLeft,
   input  logic iRight,
   input  dir_t iCommitted,
   output dir_t oPending
);

   logic [3:0] btn_prev_q, btn_prev_d;
   dir_t       pending_q, pending_d;
   logic [3:0] btn;
   logic [3:0] rise;
   dir_t       req;
   logic       req_valid;

   always_comb begin
      btn        = {iUp, iDown, iLeft, iRight};
      rise       = btn & ~btn_prev_q;
      btn_prev_d = btn;
      req        = DIR_RIGHT;
      req_valid  = 1'b1;
      if (rise[3])      req = DIR_UP;
      else if (rise[2]) req = DIR_DOWN;
      else if (rise[1]) req = DIR_LEFT;
      else if (rise[0]) req = DIR_RIGHT;
      else              req_valid = 1'b0;

      pending_d = pending_q;
      if (iReinit)
         pending_d = DIR_RIGHT;
      // The winning edge is dropped outright when it would reverse the
      // snake; lower-priority edges of the same cycle do not get a chance.
      else if (req_valid && (req != opposite(iCommitted)))
         pending_d = req;
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         btn_prev_q <= 4'b0000;
         pending_q  <= DIR_RIGHT;
      end else begin
         btn_prev_q <= btn_prev_d;
         pending_q  <= pending_d;
      end
   end

   assign oPending = pending_q;

endmodule

// File: rtl/snake_move_ctrl.sv
// Snake movement controller: holds the body segments, advances the head
// on each move tick, detects wall/self collisions and food, and answers
// per-cell pixel queries for the VGA scan.
// Ports: iCLK rising-edge clock; iRST async active-high reset; bus carries
// the tick/start strobes, buttons, food and query cells, and the outputs
// oSnake_Pix, oHead_X/Y, oLen, oEat and oState (FSM state, IDLE/RUN/CHECK/DEAD).
module snake_move_ctrl
   import snake_pkg::*;
#(
   parameter int GRID_W  = GRID_W_DEF,
   parameter int GRID_H  = GRID_H_DEF,
   parameter int MAX_LEN = MAX_LEN_DEF
)
(
   input  logic              iCLK,
   input  logic              iRST,
   snake_move_ctrl_if.slave  bus
);

   state_t     state_q, state_d;
   dir_t       dir_q, dir_d;
   logic [5:0] seg_x_q [MAX_LEN];
   logic [5:0] seg_x_d [MAX_LEN];
   logic [5:0] seg_y_q [MAX_LEN];
   logic [5:0] seg_y_d [MAX_LEN];
   logic [4:0] len_q, len_d;
   logic [5:0] nxt_x_q, nxt_x_d;
   logic [5:0] nxt_y_q, nxt_y_d;
   logic       wall_q, wall_d;
   logic       eat_q, eat_d;
   logic       pix_q, pix_d;

   dir_t       pending;
   logic       reinit;
   logic       food_hit;
   logic       self_hit;

   assign reinit = (state_q == ST_DEAD) && bus.iStart;

   snake_dir_latch u_dir_latch (
      .iCLK       (iCLK),
      .iRST       (iRST),
      .iReinit    (reinit),
      .iUp        (bus.iUpButton),
      .iDown      (bus.iDownButton),
      .iLeft      (bus.iLeftButton),
      .iRight     (bus.iRightButton),
      .iCommitted (dir_q),
      .oPending   (pending)
   );

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      seg_x_d = seg_x_q;
      seg_y_d = seg_y_q;
      len_d   = len_q;
      nxt_x_d = nxt_x_q;
      nxt_y_d = nxt_y_q;
      wall_d  = wall_q;
      eat_d   = 1'b0;
      pix_d   = 1'b0;

      for (int i = 0; i < MAX_LEN; i++)
         if ((i < int'(len_q)) && (seg_x_q[i] == bus.iQuery_X) && (seg_y_q[i] == bus.iQuery_Y))
            pix_d = 1'b1;

      food_hit = (nxt_x_q == bus.iFood_X) && (nxt_y_q == bus.iFood_Y);

      // The tail cell is free unless the snake grows on this move.
      self_hit = 1'b0;
      for (int i = 0; i < MAX_LEN; i++)
         if (((i < int'(len_q) - 1) || (food_hit && (i < int'(len_q)))) &&
             (seg_x_q[i] == nxt_x_q) && (seg_y_q[i] == nxt_y_q))
            self_hit = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (bus.iStart) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (bus.iTick) begin
               state_d = ST_CHECK;
               dir_d   = pending;
               nxt_x_d = seg_x_q[0];
               nxt_y_d = seg_y_q[0];
               // Wall is judged on the current head so the 6-bit next
               // coordinate may wrap harmlessly; it is never committed then.
               case (pending)
                  DIR_UP: begin
                     wall_d  = (seg_y_q[0] == 6'd0);
                     nxt_y_d = seg_y_q[0] - 6'd1;
                  end
                  DIR_DOWN: begin
                     wall_d  = (seg_y_q[0] == 6'(GRID_H - 1));
                     nxt_y_d = seg_y_q[0] + 6'd1;
                  end
                  DIR_LEFT: begin
                     wall_d  = (seg_x_q[0] == 6'd0);
                     nxt_x_d = seg_x_q[0] - 6'd1;
                  end
                  default: begin
                     wall_d  = (seg_x_q[0] == 6'(GRID_W - 1));
                     nxt_x_d = seg_x_q[0] + 6'd1;
                  end
               endcase
            end
         end
         ST_CHECK: begin
            if (wall_q || self_hit) begin
               state_d = ST_DEAD;
            end else begin
               for (int i = 1; i < MAX_LEN; i++) begin
                  seg_x_d[i] = seg_x_q[i-1];
                  seg_y_d[i] = seg_y_q[i-1];
               end
               seg_x_d[0] = nxt_x_q;
               seg_y_d[0] = nxt_y_q;
               if (food_hit) begin
                  eat_d = 1'b1;
                  if (int'(len_q) < MAX_LEN) len_d = len_q + 5'd1;
               end
               state_d = ST_RUN;
            end
         end
         default: begin
            if (bus.iStart) begin
               state_d = ST_IDLE;
               dir_d   = DIR_RIGHT;
               len_d   = LEN_INIT;
               for (int i = 0; i < MAX_LEN; i++) begin
                  seg_x_d[i] = init_x(i);
                  seg_y_d[i] = init_y(i);
               end
            end
         end
      endcase
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q <= ST_IDLE;
         dir_q   <= DIR_RIGHT;
         len_q   <= LEN_INIT;
         nxt_x_q <= 6'd0;
         nxt_y_q <= 6'd0;
         wall_q  <= 1'b0;
         eat_q   <= 1'b0;
         pix_q   <= 1'b0;
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_q[i] <= init_x(i);
            seg_y_q[i] <= init_y(i);
         end
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         len_q   <= len_d;
         nxt_x_q <= nxt_x_d;
         nxt_y_q <= nxt_y_d;
         wall_q  <= wall_d;
         eat_q   <= eat_d;
         pix_q   <= pix_d;
         seg_x_q <= seg_x_d;
         seg_y_q <= seg_y_d;
      end
   end

   assign bus.oSnake_Pix = pix_q;
   assign bus.oHead_X    = seg_x_q[0];
   assign bus.oHead_Y    = seg_y_q[0];
   assign bus.oLen       = len_q;
   assign bus.oEat       = eat_q;
   assign bus.oState     = state_q;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Directed testbench for snake_move_ctrl with hand-computed expectations.
module tb_snake_move_ctrl;

   logic iCLK;
   logic iRST;
   int   checks = 0;
   int   errors = 0;

   snake_move_ctrl_if bus();

   snake_move_ctrl dut (
      .iCLK (iCLK),
      .iRST (iRST),
      .bus  (bus)
   );

   // ---------------- clock ----------------
   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge iCLK);
      #1;
   endtask

   task automatic press(input logic u, input logic d, input logic l, input logic r);
      bus.iUpButton    = u;
      bus.iDownButton  = d;
      bus.iLeftButton  = l;
      bus.iRightButton = r;
      cyc();
      bus.iUpButton    = 1'b0;
      bus.iDownButton  = 1'b0;
      bus.iLeftButton  = 1'b0;
      bus.iRightButton = 1'b0;
      cyc();
   endtask

   // Tick, then one cycle in CHECK; returns just after the commit edge.
   task automatic tick();
      bus.iTick = 1'b1;
      cyc();
      bus.iTick = 1'b0;
      cyc();
   endtask

   task automatic start();
      bus.iStart = 1'b1;
      cyc();
      bus.iStart = 1'b0;
   endtask

   task automatic food(input int x, input int y);
      bus.iFood_X = 6'(x);
      bus.iFood_Y = 6'(y);
   endtask

   task automatic query(input int x, input int y);
      bus.iQuery_X = 6'(x);
      bus.iQuery_Y = 6'(y);
      cyc();
   endtask

   // ---------------- checker ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      iRST             = 1'b1;
      bus.iTick        = 1'b0;
      bus.iUpButton    = 1'b0;
      bus.iDownButton  = 1'b0;
      bus.iLeftButton  = 1'b0;
      bus.iRightButton = 1'b0;
      bus.iStart       = 1'b0;
      food(10, 10);
      bus.iQuery_X     = 6'd0;
      bus.iQuery_Y     = 6'd0;
      repeat (2) cyc();

      chk("rst_state", 32'(bus.oState), 0);
      chk("rst_len",   32'(bus.oLen), 3);
      chk("rst_hx",    32'(bus.oHead_X), 32);
      chk("rst_hy",    32'(bus.oHead_Y), 24);
      chk("rst_eat",   32'(bus.oEat), 0);
      chk("rst_pix",   32'(bus.oSnake_Pix), 0);
      iRST = 1'b0;
      cyc();

      query(31, 24);
      chk("pix_31_24", 32'(bus.oSnake_Pix), 1);
      query(40, 40);
      chk("pix_40_40", 32'(bus.oSnake_Pix), 0);

      // Three plain moves to the right.
      start();
      chk("start_run", 32'(bus.oState), 1);
      bus.iTick = 1'b1;
      cyc();
      bus.iTick = 1'b0;
      chk("in_check", 32'(bus.oState), 2);
      cyc();
      tick();
      tick();
      chk("3tick_hx",    32'(bus.oHead_X), 35);
      chk("3tick_hy",    32'(bus.oHead_Y), 24);
      chk("3tick_len",   32'(bus.oLen), 3);
      chk("3tick_state", 32'(bus.oState), 1);
      // (32,24) is a stale entry beyond oLen and must not light up.
      query(32, 24);
      chk("pix_stale", 32'(bus.oSnake_Pix), 0);

      // Reversal dropped, then Up beats Left.
      press(0, 0, 1, 0);
      tick();
      chk("rev_hx", 32'(bus.oHead_X), 36);
      chk("rev_hy", 32'(bus.oHead_Y), 24);
      press(1, 0, 1, 0);
      tick();
      chk("prio_hx", 32'(bus.oHead_X), 36);
      chk("prio_hy", 32'(bus.oHead_Y), 23);

      // Eat moving up: body becomes (36,22),(36,23),(36,24),(35,24).
      food(36, 22);
      tick();
      chk("eat1_pulse", 32'(bus.oEat), 1);
      chk("eat1_len",   32'(bus.oLen), 4);
      chk("eat1_hy",    32'(bus.oHead_Y), 22);
      food(10, 10);
      cyc();
      chk("eat1_end", 32'(bus.oEat), 0);
      query(35, 24);
      chk("eat1_tail", 32'(bus.oSnake_Pix), 1);

      // Len-4 square: the last move enters the vacating tail cell.
      press(0, 0, 1, 0);
      tick();
      press(0, 1, 0, 0);
      tick();
      press(0, 0, 0, 1);
      tick();
      chk("tail_state", 32'(bus.oState), 1);
      chk("tail_hx",    32'(bus.oHead_X), 36);
      chk("tail_hy",    32'(bus.oHead_Y), 23);

      // Grow to 5, then loop back into the body.
      food(37, 23);
      tick();
      chk("eat2_len", 32'(bus.oLen), 5);
      food(10, 10);
      press(1, 0, 0, 0);
      tick();
      press(0, 0, 1, 0);
      tick();
      press(0, 1, 0, 0);
      tick();
      chk("self_state", 32'(bus.oState), 3);
      chk("self_hx",    32'(bus.oHead_X), 36);
      chk("self_hy",    32'(bus.oHead_Y), 22);
      chk("self_len",   32'(bus.oLen), 5);
      tick();
      chk("dead_tick", 32'(bus.oState), 3);

      start();
      chk("restart_state", 32'(bus.oState), 0);
      chk("restart_hx",    32'(bus.oHead_X), 32);
      chk("restart_hy",    32'(bus.oHead_Y), 24);
      chk("restart_len",   32'(bus.oLen), 3);
      tick();
      chk("idle_tick", 32'(bus.oState), 0);

      // Right wall.
      start();
      repeat (31) tick();
      chk("wall_pre_hx", 32'(bus.oHead_X), 63);
      tick();
      chk("wall_state", 32'(bus.oState), 3);
      chk("wall_hx",    32'(bus.oHead_X), 63);
      chk("wall_hy",    32'(bus.oHead_Y), 24);
      start();
      chk("wall_idle", 32'(bus.oState), 0);

      // Eat 13 times in a row, then once more at full length.
      start();
      for (int i = 0; i < 13; i++) begin
         food(33 + i, 24);
         tick();
         if (i == 0) begin
            chk("food33_eat", 32'(bus.oEat), 1);
            chk("food33_len", 32'(bus.oLen), 4);
            query(30, 24);
            chk("food33_tail", 32'(bus.oSnake_Pix), 1);
         end
      end
      chk("full_len", 32'(bus.oLen), 16);
      chk("full_hx",  32'(bus.oHead_X), 45);
      food(46, 24);
      tick();
      chk("sat_eat", 32'(bus.oEat), 1);
      chk("sat_len", 32'(bus.oLen), 16);
      chk("sat_hx",  32'(bus.oHead_X), 46);
      food(10, 10);

      // Reset while in CHECK.
      bus.iTick = 1'b1;
      cyc();
      bus.iTick = 1'b0;
      chk("rc_in_check", 32'(bus.oState), 2);
      iRST = 1'b1;
      #1;
      chk("rc_state", 32'(bus.oState), 0);
      chk("rc_hx",    32'(bus.oHead_X), 32);
      chk("rc_len",   32'(bus.oLen), 3);
      cyc();
      iRST = 1'b0;
      cyc();
      chk("rc_hy",    32'(bus.oHead_Y), 24);
      chk("rc_state2", 32'(bus.oState), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
